// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared FSM state encoding and default widths for the UART RX frame controller.
package uart_rx_frame_ctrl_pkg;

  localparam int unsigned DEF_PAYLOAD_BITS = 8;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_EMPTY    = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

endpackage

// File: rtl/uart_rx_frame_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last,data} entries.
module uart_rx_frame_fifo
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_PAYLOAD_BITS + 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_wr,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_rd,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  // A write while full is accepted only when the head leaves in the same cycle.
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: holds the newest byte until its frame position is known,
// then pushes {last,data} into an FWFT FIFO. Optional counters: UART_RX_FRAME_CTRL_STATS_EN.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_en,
  input  logic [TIMER_W-1:0]            cfg_timeout,
  input  logic                          clr_status,
  output logic                          rx_en,
  input  logic                          rx_valid,
  input  logic                          rx_break,
  input  logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic                          m_last,
  output logic                          overflow,
  output logic                          break_seen,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef UART_RX_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]                   stat_bytes,
  output logic [15:0]                   stat_frames
`endif
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PAYLOAD_BITS-1:0] r_hold;
  logic [TIMER_W-1:0]      r_idle;
  logic                    r_rx_en;
  logic                    r_overflow;
  logic                    r_break_seen;
  logic                    w_load;
  logic                    w_push;
  logic                    w_push_last;
  logic                    w_set_break;
  logic                    w_timeout_hit;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_drop;
  logic [PAYLOAD_BITS:0]   w_rdata;

  assign w_timeout_hit = (cfg_timeout != '0) && (r_idle == cfg_timeout - 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_set_break = 1'b0;
    case (r_state)
      ST_DISABLED: if (cfg_en) w_state_nxt = ST_EMPTY;
      ST_EMPTY: begin
        w_set_break = rx_valid && rx_break;
        if (rx_valid && !rx_break) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (!cfg_en) begin
          w_state_nxt = ST_DISABLED;
        end
      end
      ST_HOLD: begin
        if (rx_valid && rx_break) begin
          w_push      = 1'b1;
          w_push_last = 1'b1;
          w_set_break = 1'b1;
          w_state_nxt = ST_EMPTY;
        end else if (rx_valid) begin
          w_push = 1'b1;
          w_load = 1'b1;
        end else if (!cfg_en) begin
          w_push      = 1'b1;
          w_push_last = 1'b1;
          w_state_nxt = ST_DISABLED;
        end else if (w_timeout_hit) begin
          w_push      = 1'b1;
          w_push_last = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_DISABLED;
    endcase
  end

  assign w_pop  = !w_empty && m_ready;
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_DISABLED;
      r_hold       <= '0;
      r_idle       <= '0;
      r_rx_en      <= 1'b0;
      r_overflow   <= 1'b0;
      r_break_seen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rx_en <= cfg_en;
      if (w_load) r_hold <= rx_data;
      if (w_load)                                   r_idle <= '0;
      else if (r_state == ST_HOLD && r_idle != '1)  r_idle <= r_idle + 1'b1;
      if (w_drop)          r_overflow <= 1'b1;
      else if (clr_status) r_overflow <= 1'b0;
      if (w_set_break)     r_break_seen <= 1'b1;
      else if (clr_status) r_break_seen <= 1'b0;
    end
  end

  uart_rx_frame_fifo #(
    .WIDTH (PAYLOAD_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_wr    (w_push),
    .i_wdata ({w_push_last, r_hold}),
    .i_rd    (m_ready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Stale RAM contents are masked so the stream outputs read 0 while empty.
  assign m_valid    = !w_empty;
  assign m_last     = !w_empty && w_rdata[PAYLOAD_BITS];
  assign m_data     = w_empty ? '0 : w_rdata[PAYLOAD_BITS-1:0];
  assign rx_en      = r_rx_en;
  assign overflow   = r_overflow;
  assign break_seen = r_break_seen;

`ifdef UART_RX_FRAME_CTRL_STATS_EN
  logic [15:0] r_stat_bytes;
  logic [15:0] r_stat_frames;
  logic        w_push_ok;

  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_bytes  <= '0;
      r_stat_frames <= '0;
    end else if (clr_status) begin
      r_stat_bytes  <= '0;
      r_stat_frames <= '0;
    end else if (w_push_ok) begin
      r_stat_bytes <= r_stat_bytes + 1'b1;
      if (w_push_last) r_stat_frames <= r_stat_frames + 1'b1;
    end
  end

  assign stat_bytes  = r_stat_bytes;
  assign stat_frames = r_stat_frames;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed scenarios plus randomized framing
// checked against a gap-versus-timeout reference model.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned PB = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned TW = 16;

  logic          clk        = 1'b0;
  logic          resetn     = 1'b0;
  logic          cfg_en     = 1'b0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          clr_status = 1'b0;
  logic          rx_valid   = 1'b0;
  logic          rx_break   = 1'b0;
  logic [PB-1:0] rx_data    = '0;
  logic          m_ready    = 1'b0;
  logic          rx_en;
  logic          m_valid;
  logic [PB-1:0] m_data;
  logic          m_last;
  logic          overflow;
  logic          break_seen;
  logic [$clog2(FD):0] fifo_level;
`ifdef UART_RX_FRAME_CTRL_STATS_EN
  logic [15:0]   stat_bytes;
  logic [15:0]   stat_frames;
`endif

  int checks   = 0;
  int failures = 0;
  logic [PB:0] got_q[$];
  logic [PB:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .PAYLOAD_BITS (PB),
    .FIFO_DEPTH   (FD),
    .TIMER_W      (TW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_en      (cfg_en),
    .cfg_timeout (cfg_timeout),
    .clr_status  (clr_status),
    .rx_en       (rx_en),
    .rx_valid    (rx_valid),
    .rx_break    (rx_break),
    .rx_data     (rx_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .overflow    (overflow),
    .break_seen  (break_seen),
    .fifo_level  (fifo_level)
`ifdef UART_RX_FRAME_CTRL_STATS_EN
    ,
    .stat_bytes  (stat_bytes),
    .stat_frames (stat_frames)
`endif
  );

  always @(negedge clk) begin
    if (resetn && m_valid && m_ready) got_q.push_back({m_last, m_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_item%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [PB-1:0] d, input logic brk);
    rx_valid = 1'b1;
    rx_break = brk;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_en"},      32'(rx_en),      32'd0);
    chk({tag, "_m_valid"},    32'(m_valid),    32'd0);
    chk({tag, "_m_last"},     32'(m_last),     32'd0);
    chk({tag, "_overflow"},   32'(overflow),   32'd0);
    chk({tag, "_break_seen"}, 32'(break_seen), 32'd0);
    chk({tag, "_level"},      32'(fifo_level), 32'd0);
  endtask

  initial begin
    int unsigned tmo;
    int unsigned gaps[24];
    logic [PB-1:0] bytes[24];
    int unsigned tot_bytes;
    int unsigned tot_frames;

    #2;
    check_all_zero("rst");
    tick();
    tick();
    resetn = 1'b1;
    cfg_en = 1'b1;
    cfg_timeout = 16'd20;
    m_ready = 1'b1;
    tick();
    chk("rx_en_follows", 32'(rx_en), 32'd1);
    tick();

    // Three bytes 5 cycles apart, closed by a 20-cycle timeout.
    strobe(8'h41, 1'b0); idle(4);
    strobe(8'h42, 1'b0); idle(4);
    strobe(8'h43, 1'b0); idle(19);
    chk("tmo_early_valid", 32'(m_valid), 32'd0);
    tick();
    chk("tmo_valid", 32'(m_valid), 32'd1);
    chk("tmo_last",  32'(m_last),  32'd1);
    chk("tmo_data",  32'(m_data),  32'h43);
    idle(3);
    exp_q.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b0, 8'h42});
    exp_q.push_back({1'b1, 8'h43});
    check_stream("frame3");

    // BREAK closes the frame and is itself discarded.
    strobe(8'h55, 1'b0); idle(2);
    strobe(8'hFF, 1'b1); idle(3);
    chk("brk_seen", 32'(break_seen), 32'd1);
    exp_q.push_back({1'b1, 8'h55});
    check_stream("brk");
    clr_pulse();
    chk("brk_clr", 32'(break_seen), 32'd0);
    rx_valid = 1'b1; rx_break = 1'b1; clr_status = 1'b1;
    tick();
    rx_valid = 1'b0; rx_break = 1'b0; clr_status = 1'b0;
    chk("brk_set_wins", 32'(break_seen), 32'd1);
    clr_pulse();
    chk("brk_clr2", 32'(break_seen), 32'd0);
    idle(2);
    check_stream("brk_empty");

    // Overflow: six back-to-back bytes into a stalled 4-entry FIFO.
    m_ready = 1'b0;
    cfg_timeout = 16'd50;
    for (int i = 0; i < 6; i++) strobe(8'h10 + 8'(i), 1'b0);
    idle(1);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag",  32'(overflow),   32'd1);
    idle(52);
    chk("ovf_level2", 32'(fifo_level), 32'd4);
    chk("ovf_flag2",  32'(overflow),   32'd1);
    clr_pulse();
    chk("ovf_clr", 32'(overflow), 32'd0);
    strobe(8'h99, 1'b0); idle(1);
    rx_valid = 1'b1; rx_break = 1'b1; m_ready = 1'b1;
    tick();
    rx_valid = 1'b0; rx_break = 1'b0; m_ready = 1'b0;
    chk("full_pp_ovf",   32'(overflow),   32'd0);
    chk("full_pp_level", 32'(fifo_level), 32'd4);
    clr_pulse();
    m_ready = 1'b1;
    idle(6);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    exp_q.push_back({1'b1, 8'h99});
    check_stream("drain");
    chk("drain_level", 32'(fifo_level), 32'd0);

    // Disable with a held byte.
    cfg_timeout = 16'd20;
    strobe(8'h7E, 1'b0); idle(2);
    cfg_en = 1'b0;
    chk("dis_rx_en_before", 32'(rx_en), 32'd1);
    tick();
    chk("dis_rx_en_after", 32'(rx_en), 32'd0);
    strobe(8'h11, 1'b0); idle(3);
    exp_q.push_back({1'b1, 8'h7E});
    check_stream("dis");
    cfg_en = 1'b1;
    idle(2);
    chk("reen_rx_en", 32'(rx_en), 32'd1);

    // Timeout disabled: second byte stays held indefinitely.
    cfg_timeout = '0;
    m_ready = 1'b0;
    strobe(8'h21, 1'b0); idle(2);
    strobe(8'h22, 1'b0); idle(1000);
    chk("t0_level", 32'(fifo_level), 32'd1);
    chk("t0_data",  32'(m_data),     32'h21);
    chk("t0_last",  32'(m_last),     32'd0);
    strobe(8'h00, 1'b1); idle(2);
    chk("t0_level2",     32'(fifo_level), 32'd2);
    chk("t0_break_seen", 32'(break_seen), 32'd1);
    strobe(8'h23, 1'b0); idle(2);
    resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    resetn = 1'b1;
    got_q.delete();
    idle(2);

    // Randomized framing: a byte ends its frame iff the gap to the next strobe exceeds the timeout.
    m_ready = 1'b1;
    clr_pulse();
    tot_bytes = 0;
    tot_frames = 0;
    for (int r = 0; r < 3; r++) begin
      tmo = $urandom_range(3, 8);
      cfg_timeout = TW'(tmo);
      for (int i = 0; i < 24; i++) begin
        gaps[i]  = $urandom_range(1, tmo + 3);
        bytes[i] = 8'($urandom);
      end
      gaps[0] = tmo;
      gaps[1] = tmo + 1;
      for (int i = 0; i < 24; i++) begin
        logic lst;
        lst = (i == 23) || (gaps[i] > tmo);
        exp_q.push_back({lst, bytes[i]});
        tot_bytes++;
        if (lst) tot_frames++;
      end
      for (int i = 0; i < 23; i++) begin
        strobe(bytes[i], 1'b0);
        idle(int'(gaps[i]) - 1);
      end
      strobe(bytes[23], 1'b0);
      idle(int'(tmo) + 5);
      check_stream($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_ovf", r), 32'(overflow), 32'd0);
    end
`ifdef UART_RX_FRAME_CTRL_STATS_EN
    chk("stat_bytes",  32'(stat_bytes),  tot_bytes);
    chk("stat_frames", 32'(stat_frames), tot_frames);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
